// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter for a shared 8-bit bidirectional pad bus. Each grant owns the
// pins for at most MAX_HOLD cycles, followed by TURN_CYC cycles with every pad released.
module uio_bus_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned TURN_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     dir,
    input  logic [8*N_REQ-1:0]   wdata,
    input  logic [7:0]           uio_in,
    output logic [7:0]           uio_out,
    output logic [7:0]           uio_oe,
    output logic [N_REQ-1:0]     grant,
    output logic [7:0]           rdata,
    output logic [N_REQ-1:0]     rvalid,
    output logic                 busy
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   owner, owner_d;
    logic [IDX_W-1:0]   last, last_d;
    logic               own_dir, dir_d;
    logic [7:0]         hold, hold_d;
    logic [3:0]         turn, turn_d;

    logic [IDX_W-1:0]   win;
    logic               found;
    logic               arb;
    logic [31:0]        last_ext;
    logic [7:0]         wbyte [N_REQ];

    logic [N_REQ-1:0]   grant_d, rvalid_d;
    logic [7:0]         oe_d, out_d;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] k);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    assign last_ext = {{(32-IDX_W){1'b0}}, last};

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            wbyte[i] = wdata[8*i +: 8];
        end
    end

    // Search begins one past the previous winner, so a preempted owner is checked last.
    always_comb begin
        int unsigned      idx;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        cand  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx  = (last_ext + 32'd1 + i) % N_REQ;
            cand = IDX_W'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d = state;
        owner_d = owner;
        last_d  = last;
        dir_d   = own_dir;
        hold_d  = hold;
        turn_d  = turn;
        arb     = 1'b0;
        unique case (state)
            IDLE: arb = 1'b1;
            OWN: begin
                if (!req[owner] || hold == 8'(MAX_HOLD)) begin
                    state_d = TURN;
                    hold_d  = '0;
                    turn_d  = 4'd1;
                end else begin
                    hold_d = hold + 8'd1;
                end
            end
            TURN: begin
                if (turn == 4'(TURN_CYC)) begin
                    state_d = IDLE;
                    turn_d  = '0;
                    arb     = 1'b1;
                end else begin
                    turn_d = turn + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (arb && found) begin
            state_d = OWN;
            owner_d = win;
            last_d  = win;
            dir_d   = dir[win];
            hold_d  = 8'd1;
        end

        // Outputs are computed from the next state so they are registered with it.
        grant_d  = '0;
        oe_d     = '0;
        out_d    = '0;
        rvalid_d = '0;
        if (state_d == OWN) begin
            grant_d = onehot(owner_d);
            if (dir_d) begin
                oe_d  = 8'hFF;
                out_d = wbyte[owner_d];
            end
        end
        if (state == OWN && state_d == OWN && !own_dir) begin
            rvalid_d = onehot(owner);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= '0;
            last    <= IDX_W'(N_REQ - 1);
            own_dir <= 1'b0;
            hold    <= '0;
            turn    <= '0;
            grant   <= '0;
            uio_oe  <= '0;
            uio_out <= '0;
            rdata   <= '0;
            rvalid  <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_d;
            owner   <= owner_d;
            last    <= last_d;
            own_dir <= dir_d;
            hold    <= hold_d;
            turn    <= turn_d;
            grant   <= grant_d;
            uio_oe  <= oe_d;
            uio_out <= out_d;
            rdata   <= uio_in;
            rvalid  <= rvalid_d;
            busy    <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter: a per-cycle vector table followed by
// hand-written preemption-rotation and mid-ownership reset sequences.
module tb_uio_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  dir;
    logic [31:0] wdata;
    logic [7:0]  uio_in;
    logic [7:0]  uio_out;
    logic [7:0]  uio_oe;
    logic [3:0]  grant;
    logic [7:0]  rdata;
    logic [3:0]  rvalid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    uio_bus_arbiter #(
        .N_REQ    (4),
        .MAX_HOLD (8),
        .TURN_CYC (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .dir     (dir),
        .wdata   (wdata),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .grant   (grant),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  dir;
        logic [31:0] wdata;
        logic [7:0]  uin;
        logic [3:0]  grant;
        logic [7:0]  oe;
        logic [7:0]  out;
        logic [3:0]  rvalid;
        logic        busy;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(name, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // Write owner, read owner with stepping pad input, dir toggle mid-ownership.
        tbl[0]  = '{4'b0001, 4'b0001, 32'h000000A5, 8'h00, 4'b0001, 8'hFF, 8'hA5, 4'b0000, 1'b1};
        tbl[1]  = '{4'b0001, 4'b0001, 32'h0000003C, 8'h00, 4'b0001, 8'hFF, 8'h3C, 4'b0000, 1'b1};
        tbl[2]  = '{4'b0000, 4'b0001, 32'h00000000, 8'h00, 4'b0000, 8'h00, 8'h00, 4'b0000, 1'b1};
        tbl[3]  = '{4'b0000, 4'b0001, 32'h00000000, 8'h00, 4'b0000, 8'h00, 8'h00, 4'b0000, 1'b0};
        tbl[4]  = '{4'b0100, 4'b0000, 32'h00000000, 8'h01, 4'b0100, 8'h00, 8'h00, 4'b0000, 1'b1};
        tbl[5]  = '{4'b0100, 4'b0000, 32'h00000000, 8'h02, 4'b0100, 8'h00, 8'h00, 4'b0100, 1'b1};
        tbl[6]  = '{4'b0100, 4'b0000, 32'h00000000, 8'h03, 4'b0100, 8'h00, 8'h00, 4'b0100, 1'b1};
        tbl[7]  = '{4'b0000, 4'b0000, 32'h00000000, 8'h04, 4'b0000, 8'h00, 8'h00, 4'b0000, 1'b1};
        tbl[8]  = '{4'b0000, 4'b0000, 32'h00000000, 8'h04, 4'b0000, 8'h00, 8'h00, 4'b0000, 1'b0};
        tbl[9]  = '{4'b1000, 4'b1000, 32'h11000000, 8'h00, 4'b1000, 8'hFF, 8'h11, 4'b0000, 1'b1};
        tbl[10] = '{4'b1001, 4'b0000, 32'h22000000, 8'h00, 4'b1000, 8'hFF, 8'h22, 4'b0000, 1'b1};
        tbl[11] = '{4'b0001, 4'b0000, 32'h00000077, 8'h00, 4'b0000, 8'h00, 8'h00, 4'b0000, 1'b1};
        tbl[12] = '{4'b0001, 4'b0000, 32'h00000077, 8'h00, 4'b0001, 8'h00, 8'h00, 4'b0000, 1'b1};
        tbl[13] = '{4'b0000, 4'b0000, 32'h00000000, 8'h00, 4'b0000, 8'h00, 8'h00, 4'b0000, 1'b1};
        tbl[14] = '{4'b0000, 4'b0000, 32'h00000000, 8'h00, 4'b0000, 8'h00, 8'h00, 4'b0000, 1'b0};

        rst_n  = 1'b0;
        req    = '0;
        dir    = '0;
        wdata  = '0;
        uio_in = '0;
        #2;
        chk("rst_grant",  {28'd0, grant},  32'd0);
        chk("rst_oe",     {24'd0, uio_oe}, 32'd0);
        chk("rst_out",    {24'd0, uio_out},32'd0);
        chk("rst_rdata",  {24'd0, rdata},  32'd0);
        chk("rst_rvalid", {28'd0, rvalid}, 32'd0);
        chk("rst_busy",   {31'd0, busy},   32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            req    = tbl[i].req;
            dir    = tbl[i].dir;
            wdata  = tbl[i].wdata;
            uio_in = tbl[i].uin;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_grant", i),  {28'd0, grant},   {28'd0, tbl[i].grant});
            chk($sformatf("v%0d_oe", i),     {24'd0, uio_oe},  {24'd0, tbl[i].oe});
            chk($sformatf("v%0d_out", i),    {24'd0, uio_out}, {24'd0, tbl[i].out});
            chk($sformatf("v%0d_rvalid", i), {28'd0, rvalid},  {28'd0, tbl[i].rvalid});
            chk($sformatf("v%0d_busy", i),   {31'd0, busy},    {31'd0, tbl[i].busy});
            chk($sformatf("v%0d_rdata", i),  {24'd0, rdata},   {24'd0, tbl[i].uin});
        end

        // Fresh reset so the rotation starts at requester 0.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;

        req   = 4'b1111;
        dir   = 4'b1111;
        wdata = 32'h44332211;
        for (int c = 0; c < 37; c++) begin
            logic [31:0] wd;
            logic [3:0]  eg;
            logic [7:0]  eoe, eout;
            int          k;
            @(posedge clk);
            #1;
            k  = (c / 9) % 4;
            wd = 32'h44332211 >> (8 * k);
            if (c % 9 == 8) begin
                eg = 4'b0000; eoe = 8'h00; eout = 8'h00;
            end else begin
                eg = 4'b0001 << k; eoe = 8'hFF; eout = wd[7:0];
            end
            chk($sformatf("rr%0d_grant", c), {28'd0, grant},   {28'd0, eg});
            chk($sformatf("rr%0d_oe", c),    {24'd0, uio_oe},  {24'd0, eoe});
            chk($sformatf("rr%0d_out", c),   {24'd0, uio_out}, {24'd0, eout});
        end
        req = '0;
        wait_idle("rr_idle");

        // Reset between edges while a write owner is driving the pads.
        req   = 4'b0001;
        dir   = 4'b0001;
        wdata = 32'h0000005A;
        @(posedge clk);
        #1;
        chk("pre_rst_oe",    {24'd0, uio_oe}, 32'h000000FF);
        chk("pre_rst_grant", {28'd0, grant},  32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_oe",    {24'd0, uio_oe}, 32'd0);
        chk("async_grant", {28'd0, grant},  32'd0);
        chk("async_busy",  {31'd0, busy},   32'd0);
        chk("async_out",   {24'd0, uio_out},32'd0);
        req = 4'b1010;
        dir = 4'b0000;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_grant", {28'd0, grant},  32'h2);
        chk("post_rst_oe",    {24'd0, uio_oe}, 32'd0);
        chk("post_rst_busy",  {31'd0, busy},   32'd1);
        req = '0;
        wait_idle("final_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
